bcd_counter4: RTL and testbench

- 4-digit BCD up/down counter with an internal prescaler and start/stop/clear control.
- Sits directly upstream of the board's 7-segment decoders: each 4-bit digit output drives one decoder's 4-bit value input.
- Every digit output is always a legal BCD value (0-9), so the decoders never receive 10-15 from this block.

---
 rtl/bcd_counter4_if.sv | 46 ++++
 rtl/bcd_counter4.sv | 217 +++++++++++++++++++++
 tb/tb_bcd_counter4.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_counter4_if.sv
// bcd_counter4_if: key inputs and display outputs of bcd_counter4.
// master drives the keys and watches the display; slave is the counter.
interface bcd_counter4_if;
    logic       start;
    logic       clr;
    logic       up;
    logic       lap;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic [3:0] dig3;
    logic       running;
    logic       tick;
    logic       wrap;
    logic       frozen;

    modport master (
        output start,
        output clr,
        output up,
        output lap,
        input  dig0,
        input  dig1,
        input  dig2,
        input  dig3,
        input  running,
        input  tick,
        input  wrap,
        input  frozen
    );

    modport slave (
        input  start,
        input  clr,
        input  up,
        input  lap,
        output dig0,
        output dig1,
        output dig2,
        output dig3,
        output running,
        output tick,
        output wrap,
        output frozen
    );
endinterface

// File: rtl/bcd_counter4.sv
// bcd_counter4: 4-digit BCD up/down counter with prescaler and start/stop/clear.
// Define BCD_COUNTER4_LAP_EN to add the lap/freeze display capture.
module bcd_counter4 #(
    parameter int DIV   = 50000000,
    parameter int DIV_W = 26
) (
    input logic           clk,
    input logic           rst,
    bcd_counter4_if.slave bus
);
    localparam logic [DIV_W-1:0] TERM = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] ONE  = DIV_W'(1);

    typedef enum logic {
        ST_STOP,
        ST_RUN
    } run_t;

    run_t             state;
    run_t             state_nxt;
    logic             start_q;
    logic             start_rise;
    logic             run;
    logic [DIV_W-1:0] pre;
    logic [DIV_W-1:0] pre_nxt;
    logic             term;
    logic             tick_nxt;
    logic             wrap_nxt;
    logic             tick_q;
    logic             wrap_q;
    logic [3:0][3:0]  cnt;
    logic [3:0][3:0]  cnt_nxt;
    logic [3:0][3:0]  cnt_up;
    logic [3:0][3:0]  cnt_dn;
    logic             up_wrap;
    logic             dn_wrap;
    logic [3:0][3:0]  shown;

    // start key edge detector
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b0;
        end else begin
            start_q <= bus.start;
        end
    end

    assign start_rise = bus.start & ~start_q;

    // run state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_STOP;
        end else begin
            state <= state_nxt;
        end
    end

    // each start edge toggles between stopped and running
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_STOP: if (start_rise) state_nxt = ST_RUN;
            ST_RUN:  if (start_rise) state_nxt = ST_STOP;
            default: state_nxt = ST_STOP;
        endcase
    end

    // tick uses the registered run state, so a
    // simultaneous stop still lets a terminal tick through
    assign run      = (state == ST_RUN);
    assign term     = (pre == TERM);
    assign tick_nxt = run & ~bus.clr & term;

    // prescaler next value; holds while stopped
    always_comb begin
        pre_nxt = pre;
        unique case (1'b1)
            bus.clr:                 pre_nxt = '0;
            tick_nxt:                pre_nxt = '0;
            (run & ~term & ~bus.clr): pre_nxt = pre + ONE;
            default:                 pre_nxt = pre;
        endcase
    end

    // ripple increment across the digits
    always_comb begin
        logic carry;
        cnt_up = cnt;
        carry  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (cnt[i] == 4'd9) begin
                    cnt_up[i] = 4'd0;
                end else begin
                    cnt_up[i] = cnt[i] + 4'd1;
                    carry     = 1'b0;
                end
            end
        end
        up_wrap = carry;
    end

    // ripple decrement across the digits
    always_comb begin
        logic borrow;
        cnt_dn = cnt;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (cnt[i] == 4'd0) begin
                    cnt_dn[i] = 4'd9;
                end else begin
                    cnt_dn[i] = cnt[i] - 4'd1;
                    borrow    = 1'b0;
                end
            end
        end
        dn_wrap = borrow;
    end

    // count next value: clear beats a step
    always_comb begin
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        unique case (1'b1)
            bus.clr: begin
                cnt_nxt = '0;
            end
            (tick_nxt & bus.up): begin
                cnt_nxt  = cnt_up;
                wrap_nxt = up_wrap;
            end
            (tick_nxt & ~bus.up): begin
                cnt_nxt  = cnt_dn;
                wrap_nxt = dn_wrap;
            end
            default: begin
                cnt_nxt = cnt;
            end
        endcase
    end

    // prescaler, live count and step pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            pre    <= '0;
            cnt    <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            pre    <= pre_nxt;
            cnt    <= cnt_nxt;
            tick_q <= tick_nxt;
            wrap_q <= wrap_nxt;
        end
    end

`ifdef BCD_COUNTER4_LAP_EN
    logic            lap_q;
    logic            lap_rise;
    logic            frz_q;
    logic [3:0][3:0] cap;

    // lap key edge detector
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_q <= 1'b0;
        end else begin
            lap_q <= bus.lap;
        end
    end

    assign lap_rise = bus.lap & ~lap_q;

    // lap edges alternately capture and release the display
    always_ff @(posedge clk) begin
        if (rst) begin
            frz_q <= 1'b0;
            cap   <= '0;
        end else begin
            unique case (1'b1)
                bus.clr: begin
                    frz_q <= 1'b0;
                end
                (lap_rise & ~frz_q): begin
                    cap   <= cnt;
                    frz_q <= 1'b1;
                end
                (lap_rise & frz_q): begin
                    frz_q <= 1'b0;
                end
                default: begin
                    frz_q <= frz_q;
                end
            endcase
        end
    end

    assign shown      = frz_q ? cap : cnt;
    assign bus.frozen = frz_q;
`else
    logic unused_lap;

    assign unused_lap = bus.lap;
    assign shown      = cnt;
    assign bus.frozen = 1'b0;
`endif

    assign bus.dig0    = shown[0];
    assign bus.dig1    = shown[1];
    assign bus.dig2    = shown[2];
    assign bus.dig3    = shown[3];
    assign bus.running = run;
    assign bus.tick    = tick_q;
    assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_bcd_counter4.sv
// tb_bcd_counter4: directed bench for bcd_counter4 at DIV=4 and DIV=1.
// An integer-valued model is compared against both instances every cycle.
module tb_bcd_counter4;
    logic clk = 1'b0;
    logic rst4;
    logic rst1;
    int   checks = 0;
    int   errors = 0;
    bit   armed  = 1'b0;

`ifdef BCD_COUNTER4_LAP_EN
    localparam int LAP = 1;
`else
    localparam int LAP = 0;
`endif

    always #5 clk = ~clk;

    bcd_counter4_if b4 ();
    bcd_counter4_if b1 ();

    bcd_counter4 #(.DIV(4), .DIV_W(3)) u4 (
        .clk(clk),
        .rst(rst4),
        .bus(b4)
    );

    bcd_counter4 #(.DIV(1), .DIV_W(1)) u1 (
        .clk(clk),
        .rst(rst1),
        .bus(b1)
    );

    int divs [2] = '{4, 1};
    int m_cnt [2];
    int m_pre [2];
    int m_cap [2];
    bit m_run [2];
    bit m_tick [2];
    bit m_wrap [2];
    bit m_sq [2];
    bit m_lq [2];
    bit m_frz [2];

    task automatic mstep(input int k, input bit r, input bit s,
                         input bit c, input bit u, input bit l);
        bit sr;
        bit tn;
        int old;
        sr  = s && !m_sq[k];
        old = m_cnt[k];
        if (r) begin
            m_cnt[k]  = 0;
            m_pre[k]  = 0;
            m_cap[k]  = 0;
            m_run[k]  = 0;
            m_tick[k] = 0;
            m_wrap[k] = 0;
            m_sq[k]   = 0;
            m_lq[k]   = 0;
            m_frz[k]  = 0;
        end else begin
            tn        = m_run[k] && !c && (m_pre[k] == divs[k] - 1);
            m_tick[k] = tn;
            m_wrap[k] = 0;
            if (c) begin
                m_cnt[k] = 0;
                m_pre[k] = 0;
                m_frz[k] = 0;
            end else begin
                if (m_run[k]) m_pre[k] = tn ? 0 : m_pre[k] + 1;
                if (tn && u) begin
                    m_cnt[k]  = (old + 1) % 10000;
                    m_wrap[k] = (old == 9999);
                end else if (tn) begin
                    m_cnt[k]  = (old + 9999) % 10000;
                    m_wrap[k] = (old == 0);
                end
                if (LAP == 1 && l && !m_lq[k]) begin
                    if (!m_frz[k]) begin
                        m_cap[k] = old;
                        m_frz[k] = 1;
                    end else begin
                        m_frz[k] = 0;
                    end
                end
            end
            if (sr) m_run[k] = !m_run[k];
            m_sq[k] = s;
            m_lq[k] = l;
        end
    endtask

    function automatic logic [19:0] mexp(input int k);
        int v;
        v = m_frz[k] ? m_cap[k] : m_cnt[k];
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10),
                4'(v % 10), m_run[k], m_tick[k], m_wrap[k], m_frz[k]};
    endfunction

    function automatic logic [19:0] dut(input int k);
        if (k == 0)
            return {b4.dig3, b4.dig2, b4.dig1, b4.dig0,
                    b4.running, b4.tick, b4.wrap, b4.frozen};
        return {b1.dig3, b1.dig2, b1.dig1, b1.dig0,
                b1.running, b1.tick, b1.wrap, b1.frozen};
    endfunction

    function automatic int dval4();
        return int'(b4.dig3) * 1000 + int'(b4.dig2) * 100 +
               int'(b4.dig1) * 10 + int'(b4.dig0);
    endfunction

    function automatic int dval1();
        return int'(b1.dig3) * 1000 + int'(b1.dig2) * 100 +
               int'(b1.dig1) * 10 + int'(b1.dig0);
    endfunction

    // advance the model on the same edge as the DUTs
    always @(posedge clk) begin
        mstep(0, rst4, b4.start, b4.clr, b4.up, b4.lap);
        mstep(1, rst1, b1.start, b1.clr, b1.up, b1.lap);
        armed = 1'b1;
    end

    // compare every output of both instances mid-cycle
    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dut(k) !== mexp(k)) begin
                    errors++;
                    $display("FAIL model%0d t=%0t got=%h exp=%h",
                             k, $time, dut(k), mexp(k));
                end
            end
        end
    end

    task automatic chk(input string n, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", n, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int ticks;
        int wraps;
        int maxd;
        rst4 = 1'b1;
        rst1 = 1'b1;
        b4.start = 0; b4.clr = 0; b4.up = 1; b4.lap = 0;
        b1.start = 0; b1.clr = 0; b1.up = 1; b1.lap = 0;
        step(2);
        rst4 = 1'b0;
        rst1 = 1'b0;
        chk("rst_dig", dval4(), 0);
        chk("rst_run", int'(b4.running), 0);
        chk("rst_tick", int'(b4.tick), 0);
        chk("rst_frz", int'(b4.frozen), 0);

        // start, then tick every 4th cycle
        b4.start = 1;
        step(1);
        b4.start = 0;
        chk("start_run", int'(b4.running), 1);
        step(3);
        chk("pre_notick", int'(b4.tick), 0);
        step(1);
        chk("tick1", int'(b4.tick), 1);
        chk("tick1_dig", dval4(), 1);
        step(4);
        chk("tick2", int'(b4.tick), 1);
        chk("tick2_dig", dval4(), 2);

        // stop mid-period, resume, hold start high
        step(1);
        b4.start = 1;
        step(1);
        b4.start = 0;
        chk("stop_run", int'(b4.running), 0);
        step(20);
        chk("stop_hold", dval4(), 2);
        b4.start = 1;
        step(1);
        chk("restart_run", int'(b4.running), 1);
        step(1);
        chk("restart_notick", int'(b4.tick), 0);
        step(1);
        chk("restart_tick", int'(b4.tick), 1);
        chk("restart_dig", dval4(), 3);
        step(8);
        chk("hold_run", int'(b4.running), 1);
        b4.start = 0;
        step(1);
        chk("hold_run2", int'(b4.running), 1);

        // clear on a terminal prescaler cycle at 0009
        b4.clr = 1;
        step(1);
        b4.clr = 0;
        chk("clr_dig", dval4(), 0);
        step(39);
        chk("pre_clr_dig", dval4(), 9);
        b4.clr = 1;
        step(1);
        b4.clr = 0;
        chk("clr9_dig", dval4(), 0);
        chk("clr9_tick", int'(b4.tick), 0);
        chk("clr9_wrap", int'(b4.wrap), 0);
        chk("clr9_run", int'(b4.running), 1);

        // full up lap at DIV=1
        b1.start = 1;
        step(1);
        b1.start = 0;
        chk("d1_run", int'(b1.running), 1);
        ticks = 0;
        wraps = 0;
        maxd  = 0;
        for (int i = 0; i < 10000; i++) begin
            step(1);
            if (b1.tick) ticks++;
            if (b1.wrap) begin
                wraps++;
                chk("wrap_at_zero", dval1(), 0);
            end
            if (int'(b1.dig0) > maxd) maxd = int'(b1.dig0);
            if (int'(b1.dig1) > maxd) maxd = int'(b1.dig1);
            if (int'(b1.dig2) > maxd) maxd = int'(b1.dig2);
            if (int'(b1.dig3) > maxd) maxd = int'(b1.dig3);
        end
        chk("up_ticks", ticks, 10000);
        chk("up_wraps", wraps, 1);
        chk("up_end", dval1(), 0);
        chk("max_digit", maxd, 9);

        // down count with wrap and chained borrow
        b1.up = 0;
        step(1);
        chk("dn_9999", dval1(), 9999);
        chk("dn_wrap", int'(b1.wrap), 1);
        step(1);
        chk("dn_9998", dval1(), 9998);
        chk("dn_nowrap", int'(b1.wrap), 0);
        step(8998);
        chk("dn_1000", dval1(), 1000);
        step(1);
        chk("dn_0999", dval1(), 999);

        // direction change while stopped never steps
        b1.start = 1;
        step(1);
        b1.start = 0;
        chk("d1_stop", int'(b1.running), 0);
        chk("d1_last", dval1(), 998);
        b1.up = 1;
        step(3);
        chk("dir_hold", dval1(), 998);

        // reset mid-count
        rst4 = 1;
        step(1);
        rst4 = 0;
        chk("mid_rst_dig", dval4(), 0);
        chk("mid_rst_run", int'(b4.running), 0);
        step(1);
        chk("mid_rst_tick", int'(b4.tick), 0);
        chk("mid_rst_wrap", int'(b4.wrap), 0);

        // lap freeze and release
        rst1 = 1;
        step(1);
        rst1 = 0;
        b1.start = 1;
        step(1);
        b1.start = 0;
        step(42);
        chk("lap_pre", dval1(), 42);
        b1.lap = 1;
        step(1);
        b1.lap = 0;
        if (LAP == 1) begin
            for (int i = 0; i < 30; i++) begin
                chk("lap_hold", dval1(), 42);
                chk("lap_frz", int'(b1.frozen), 1);
                step(1);
            end
            b1.lap = 1;
            step(1);
            b1.lap = 0;
            chk("lap_live", dval1(), 74);
            chk("lap_unfrz", int'(b1.frozen), 0);
        end else begin
            chk("nolap_frz", int'(b1.frozen), 0);
            chk("nolap_live", dval1(), 43);
        end
        b1.lap = 1;
        step(1);
        b1.lap = 0;
        chk("lap2_frz", int'(b1.frozen), LAP);
        b1.clr = 1;
        step(1);
        b1.clr = 0;
        chk("clr_frz", int'(b1.frozen), 0);
        chk("clr_live", dval1(), 0);

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
